gelu_unit: RTL and testbench
============================

GELU_UNIT -- requirements
Module: gelu_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  in  1  reset; asynchronous assert, active-low (0 = reset).
REQ-003 SHALL have ports: data_in_valid  in  1  input beat valid.
REQ-004 SHALL have ports: data_in_ready  out  1  input beat accepted when high with data_in_valid.
REQ-005 SHALL have ports: in_data  in  256  32 signed int8 elements; element i = bits [8i+7:8i].
REQ-006 SHALL have ports: in_scale  in  32  unsigned Q16.16 real value of one input LSB (S_in).
REQ-007 SHALL have ports: out_scale  in  32  unsigned Q16.16 reciprocal of output LSB value (1/S_out).
REQ-008 SHALL have ports: data_out_valid  out  1  output beat valid.
REQ-009 SHALL have ports: data_out_ready  in  1  downstream accepts output beat.
REQ-010 SHALL have ports: out_data  out  256  32 signed int8 results, same lane mapping as in_data.

Function
REQ-011 SHALL compute per lane: x = q_in*S_in; y = GELU(x); q_out = round(y*(1/S_out)), saturated to [-128,127].
REQ-012 SHALL approximate GELU as y = 0.5*x*(1+L(x/sqrt2)), L(u) = sign(u)*(a*(min(|u|,-b)+b)^2 + 1), a = -0.2888, b = -1.769.
REQ-013 SHALL carry all intermediates in signed fixed point with at least 16 fractional bits; no intermediate overflow for any int8 input with scales up to 255.0.
REQ-014 SHALL round final result to nearest, ties away from zero, then saturate.
REQ-015 SHALL process all 32 lanes in parallel; one beat per cycle throughput when unstalled.
REQ-016 SHALL be a 4-stage pipeline: accepted beat at edge N appears with data_out_valid high after edge N+4 when never stalled.
REQ-017 SHALL capture in_scale and out_scale with each accepted beat; scales may change every beat and each beat uses its own scales.
REQ-018 SHALL advance the pipeline when data_out_valid is 0 or data_out_ready is 1; data_in_ready SHALL equal this advance condition (combinational).
REQ-019 SHALL hold out_data and data_out_valid stable while data_out_valid=1 and data_out_ready=0.
REQ-020 SHALL not drop, duplicate or reorder beats; bubbles (valid=0) propagate as bubbles.
REQ-021 SHALL ignore in_data/scales when data_in_valid=0 or data_in_ready=0.
REQ-022 SHALL map q_in=0 to q_out=0 exactly for any scales.
REQ-023 SHALL produce q_out = saturate(round(x/S_out)) for x >= 1.769*sqrt2 and q_out = 0 for x <= -1.769*sqrt2.

Reset
REQ-024 SHALL, while rst=0, clear all stage valid bits, data_out_valid=0, out_data=0, captured scales=0, independent of clk.
REQ-025 SHALL discard in-flight beats on reset assertion mid-operation; first accepted beat after release follows REQ-016 latency.
REQ-026 SHALL drive data_in_ready=1 during and immediately after reset (pipeline empty).

Verification
REQ-027 Reset: rst=0 with random inputs -> data_out_valid=0, out_data=0, data_in_ready=1.
REQ-028 Identity region: in_scale=1.0, out_scale=1.0, all lanes {0,100,-100,127,-128,3,-3,5} -> {0,100,0,127,0,3,0,5} 4 cycles after acceptance (3 and -3 lie at the GELU tails: 3 -> 3, -3 -> 0).
REQ-029 Curved region: in_scale=1.0, out_scale=16.0, lane q_in=1 -> q_out=13 (+-1 LSB); q_in=-1 -> -3 (+-1 LSB); saturation: in_scale=4.0, out_scale=16.0, q_in=127 -> 127.
REQ-030 Backpressure: stream 10 distinct beats, hold data_out_ready=0 for 6 cycles mid-stream -> data_in_ready falls once output valid, output held stable, all 10 results delivered in order without loss.
REQ-031 Per-beat scales: alternate in_scale 1.0/0.5 on consecutive beats with q_in=100 -> outputs alternate 100/50.
REQ-032 Random: 10k random beats/scales with random ready/valid -> every lane within +-1 LSB of a double-precision model of REQ-011/012.

Source files
------------

// File: rtl/gelu_unit.sv
// 32-lane int8 GELU (sign-split erf polynomial) with per-beat Q16.16 scales.
// Five register levels give a 4-cycle acceptance-to-valid latency; all stages stall together.
module gelu_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  input  logic [255:0] in_data,
  input  logic [31:0]  in_scale,
  input  logic [31:0]  out_scale,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic [255:0] out_data
);
  localparam int          LANES     = 32;
  localparam logic [16:0] INV_SQRT2 = 17'd46341;   // 1/sqrt2 in Q.16
  localparam logic [16:0] U_CLAMP   = 17'd115933;  // 1.769 in Q.16
  localparam logic [14:0] A_MAG     = 15'd18927;   // |a| = 0.2888 in Q.16
  localparam logic [17:0] TWO       = 18'd131072;  // 2.0 in Q.16

  logic        adv;
  logic [4:0]  vld_q;
  logic [31:0] in_scale_q;
  logic [31:0] out_scale_q;
  logic [31:0] out_scale_b_q;

  assign adv            = !vld_q[4] || data_out_ready;
  assign data_in_ready  = adv;
  assign data_out_valid = vld_q[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q         <= '0;
      in_scale_q    <= '0;
      out_scale_q   <= '0;
      out_scale_b_q <= '0;
    end else if (adv) begin
      vld_q         <= {vld_q[3:0], data_in_valid};
      out_scale_b_q <= out_scale_q;
      if (data_in_valid) begin
        in_scale_q  <= in_scale;
        out_scale_q <= out_scale;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [7:0]  q_q;
    logic signed [40:0] x_d, x_q;
    logic [40:0]        ax;
    logic [57:0]        u;
    logic [16:0]        t_d, t_q;
    logic signed [57:0] xs_d, xs_q, xs3_q;
    logic               neg_q;
    logic [17:0]        t2;
    logic [16:0]        at;
    logic [17:0]        h_d, h_q;
    logic signed [76:0] v;
    logic [76:0]        v_mag;
    logic [43:0]        r;
    logic signed [7:0]  o_d, o_q;

    // t is min(|u|,1.769)-1.769 kept as a magnitude, since only its square is needed.
    // 1+L(u) collapses to 2-|a|t^2 for x>=0 and |a|t^2 for x<0.
    always_comb begin
      x_d   = 41'(q_q) * 41'($signed({1'b0, in_scale_q}));
      ax    = x_q[40] ? -x_q : x_q;
      u     = (58'(ax) * 58'(INV_SQRT2)) >> 16;
      t_d   = U_CLAMP - ((u > 58'(U_CLAMP)) ? U_CLAMP : 17'(u));
      xs_d  = 58'((74'(x_q) * 74'($signed({1'b0, out_scale_b_q}))) >>> 16);
      t2    = 18'((34'(t_q) * 34'(t_q)) >> 16);
      at    = 17'((33'(t2) * 33'(A_MAG)) >> 16);
      h_d   = neg_q ? 18'(at) : TWO - 18'(at);
      // v = 2*y/S_out in Q.32, so the final shift by 33 also applies the 0.5 factor.
      v     = 77'(xs3_q) * 77'($signed({1'b0, h_q}));
      v_mag = v[76] ? -v : v;
      r     = 44'((v_mag + (77'd1 << 32)) >> 33);
      if (!v[76]) begin
        o_d = (r > 44'd127) ? 8'h7f : 8'(r);
      end else begin
        o_d = (r > 44'd128) ? 8'h80 : 8'(-r);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q_q   <= '0;
        x_q   <= '0;
        t_q   <= '0;
        xs_q  <= '0;
        neg_q <= 1'b0;
        h_q   <= '0;
        xs3_q <= '0;
        o_q   <= '0;
      end else if (adv) begin
        if (data_in_valid) begin
          q_q <= in_data[8*gi +: 8];
        end
        x_q   <= x_d;
        t_q   <= t_d;
        xs_q  <= xs_d;
        neg_q <= x_q[40];
        h_q   <= h_d;
        xs3_q <= xs_q;
        if (vld_q[3]) begin
          o_q <= o_d;
        end
      end
    end

    assign out_data[8*gi +: 8] = o_q;
  end

endmodule

// File: tb/tb_gelu_unit.sv
// Self-checking bench for gelu_unit: directed cases plus randomized traffic
// scored against a real-valued GELU reference model.
module tb_gelu_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [255:0] in_data = '0;
  logic [31:0]  in_scale = '0;
  logic [31:0]  out_scale = '0;
  logic         data_out_valid;
  logic         data_out_ready = 1'b1;
  logic [255:0] out_data;

  always #5 clk = ~clk;

  gelu_unit dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .in_data        (in_data),
    .in_scale       (in_scale),
    .out_scale      (out_scale),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .out_data       (out_data)
  );

  typedef struct {
    logic [255:0] exp;
    int           tol;
    bit           chk_lat;
    longint       acc_cyc;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        mon_b;
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  longint       cyc = 0;
  int           rdy_mode = 0;
  bit           sb_en = 1'b0;
  bit           saw_stall = 1'b0;
  bit           held = 1'b0;
  logic [255:0] held_data = '0;

  localparam logic [31:0] ONE = 32'd65536;

  task automatic check_val(input string tag, input longint obs, input longint exp, input int tol);
    longint d;
    d = obs - exp;
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int gelu_ref(input int q, input longint si, input longint so);
    real x, u, m, l, y, v, r;
    x = q * (si / 65536.0);
    u = x / $sqrt(2.0);
    m = (u < 0.0) ? -u : u;
    if (m > 1.769) m = 1.769;
    l = -0.2888 * (m - 1.769) * (m - 1.769) + 1.0;
    if (u < 0.0) l = -l;
    else if (u == 0.0) l = 0.0;
    y = 0.5 * x * (1.0 + l);
    v = y * (so / 65536.0);
    r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    if (r > 127.0) return 127;
    if (r < -128.0) return -128;
    return int'(r);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [255:0] model_beat(input logic [255:0] d, input logic [31:0] si,
                                              input logic [31:0] so);
    logic [255:0] e;
    for (int i = 0; i < 32; i++) begin
      e[8*i +: 8] = 8'(gelu_ref(int'($signed(d[8*i +: 8])), longint'(si), longint'(so)));
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output ready shaping: 0 = always ready, 1 = random, 2 = held off.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       data_out_ready = 1'b1;
      1:       data_out_ready = ($urandom_range(0, 9) < 7);
      default: data_out_ready = 1'b0;
    endcase
  end

  // Scoreboard and handshake rules, sampled on the falling edge.
  always @(negedge clk) begin
    if (!sb_en) begin
      held <= 1'b0;
    end else begin
      check_val("in_ready_rule", longint'(data_in_ready),
                longint'(!data_out_valid || data_out_ready), 0);
      if (held) begin
        check_val("hold_valid", longint'(data_out_valid), 1, 0);
        check_val("hold_data", longint'(out_data == held_data), 1, 0);
      end
      held      <= data_out_valid && !data_out_ready;
      held_data <= out_data;
      if (data_out_valid && !data_out_ready) saw_stall <= 1'b1;
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0, 0);
        end else begin
          mon_b = exp_q.pop_front();
          for (int i = 0; i < 32; i++) begin
            check_val($sformatf("beat%0d_lane%0d", n_out, i), longint'($signed(out_data[8*i +: 8])),
                      longint'($signed(mon_b.exp[8*i +: 8])), mon_b.tol);
          end
          if (mon_b.chk_lat) check_val($sformatf("latency%0d", n_out), cyc - mon_b.acc_cyc, 5, 0);
          n_out++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] si, input logic [31:0] so,
                           input logic [255:0] e, input int tol, input bit lat);
    int    w;
    beat_t b;
    w             = 0;
    in_data       = d;
    in_scale      = si;
    out_scale     = so;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!data_in_ready) begin
      check_val("accept_timeout", 0, 1, 0);
    end else begin
      b.exp     = e;
      b.tol     = tol;
      b.chk_lat = lat;
      b.acc_cyc = cyc;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    in_data       = rand256();
    in_scale      = $urandom;
    out_scale     = $urandom;
  endtask

  task automatic idle_cycle();
    data_in_valid = 1'b0;
    in_data       = rand256();
    in_scale      = $urandom;
    out_scale     = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) check_val("drain", exp_q.size(), 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d, e;
    logic [31:0]  si, so;
    int           pat_in [8] = '{0, 100, -100, 127, -128, 3, -3, 5};
    int           pat_out[8] = '{0, 100, 0, 127, 0, 3, 0, 5};

    // Reset held with live, random inputs.
    data_in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data   = rand256();
      in_scale  = $urandom;
      out_scale = $urandom;
      @(posedge clk);
      #1;
      check_val("rst_out_valid", longint'(data_out_valid), 0, 0);
      check_val("rst_out_data_nonzero", longint'(out_data != '0), 0, 0);
      check_val("rst_in_ready", longint'(data_in_ready), 1, 0);
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", longint'(data_in_ready), 1, 0);
    sb_en = 1'b1;

    // Identity region with latency check.
    for (int i = 0; i < 32; i++) begin
      d[8*i +: 8] = 8'(pat_in[i % 8]);
      e[8*i +: 8] = 8'(pat_out[i % 8]);
    end
    send_beat(d, ONE, ONE, e, 0, 1'b1);
    drain();

    // Curved region and saturation.
    for (int i = 0; i < 32; i++) begin
      d[8*i +: 8] = (i % 2 == 0) ? 8'sd1 : -8'sd1;
      e[8*i +: 8] = (i % 2 == 0) ? 8'sd13 : -8'sd3;
    end
    send_beat(d, ONE, 32'd16 * ONE, e, 1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      d[8*i +: 8] = (i % 2 == 0) ? 8'sd127 : 8'h80;
      e[8*i +: 8] = (i % 2 == 0) ? 8'sd127 : 8'sd0;
    end
    send_beat(d, 32'd4 * ONE, 32'd16 * ONE, e, 0, 1'b1);

    // Per-beat scales, back to back.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 32; i++) begin
        d[8*i +: 8] = 8'sd100;
        e[8*i +: 8] = (b % 2 == 0) ? 8'sd100 : 8'sd50;
      end
      send_beat(d, (b % 2 == 0) ? ONE : ONE / 2, ONE, e, 0, 1'b1);
    end

    // Zero input maps to zero for any scales.
    for (int b = 0; b < 3; b++) begin
      send_beat('0, $urandom_range(0, 255 * 65536), $urandom_range(0, 255 * 65536), '0, 0, 1'b1);
    end
    drain();

    // Backpressure mid-stream.
    saw_stall = 1'b0;
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          d  = rand256();
          so = $urandom_range(ONE / 2, 4 * ONE);
          send_beat(d, ONE, so, model_beat(d, ONE, so), 1, 1'b0);
        end
      end
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 2;
        repeat (6) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    check_val("bp_stall_seen", longint'(saw_stall), 1, 0);

    // Reset asserted mid-operation discards in-flight beats.
    for (int b = 0; b < 3; b++) begin
      d = rand256();
      send_beat(d, ONE, ONE, model_beat(d, ONE, ONE), 1, 1'b0);
    end
    sb_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_out_valid", longint'(data_out_valid), 0, 0);
    check_val("midrst_out_data_nonzero", longint'(out_data != '0), 0, 0);
    check_val("midrst_in_ready", longint'(data_in_ready), 1, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_en = 1'b1;
    d = rand256();
    send_beat(d, ONE, 32'd8 * ONE, model_beat(d, ONE, 32'd8 * ONE), 1, 1'b1);
    drain();

    // Randomized traffic with random bubbles and output backpressure.
    rdy_mode = 1;
    for (int b = 0; b < 10000; b++) begin
      if (n_err > 100) break;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) idle_cycle();
      end
      case ($urandom_range(0, 3))
        0:       si = $urandom_range(0, 2 * 65536);
        1:       si = $urandom_range(0, 255 * 65536);
        2:       si = ONE >> $urandom_range(0, 6);
        default: si = $urandom_range(0, 8192);
      endcase
      case ($urandom_range(0, 3))
        0:       so = $urandom_range(0, 64 * 65536);
        1:       so = $urandom_range(0, 255 * 65536);
        2:       so = $urandom_range(65536, 16 * 65536);
        default: so = $urandom_range(0, 65536);
      endcase
      d = rand256();
      send_beat(d, si, so, model_beat(d, si, so), 1, 1'b0);
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
